// File: rtl/vga_pkg.sv
// Shared screen geometry, SRAM address width and the pixel-responder FSM states.
package vga_pkg;
  localparam int SCREEN_WIDTH_DEF  = 320;
  localparam int SCREEN_HEIGHT_DEF = 240;
  localparam int ADDR_W            = 17;

  typedef enum logic [3:0] {
    IDLE, ARB, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_SAMPLE, DONE, RELEASE
  } pixelState_t;
endpackage

// File: rtl/pixel_address_calc.sv
// Combinational pixel address (row-major, Y*width+X) and screen range check.
module pixel_address_calc import vga_pkg::*; #(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
  input  logic [8:0]        xCoord,
  input  logic [7:0]        yCoord,
  output logic [ADDR_W-1:0] pixelAddress,
  output logic              inRange
);
  logic [ADDR_W-1:0] xExt, yExt;

  assign xExt = ADDR_W'(xCoord);
  assign yExt = ADDR_W'(yCoord);

  // 320 = 256 + 64, so the default width needs only two shifts and an add
  generate
    if (SCREEN_WIDTH == 320) begin : g_shiftAdd
      assign pixelAddress = (yExt << 8) + (yExt << 6) + xExt;
    end else begin : g_mult
      assign pixelAddress = yExt * ADDR_W'(SCREEN_WIDTH) + xExt;
    end
  endgenerate

  assign inRange = (int'(xCoord) < SCREEN_WIDTH) && (int'(yCoord) < SCREEN_HEIGHT);
endmodule

// File: rtl/mpu_pixel_responder.sv
// Serves single-pixel MPU reads/writes against the shared frame-buffer SRAM,
// arbitrating for the bus and sequencing WE#/OE# with fully registered outputs.
module mpu_pixel_responder import vga_pkg::*; #(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8:0]        memoryXCoord,
  input  logic [7:0]        memoryYCoord,
  input  logic              memoryWriteRequest,
  input  logic              memoryReadRequest,
  input  logic [7:0]        memoryWriteData,
  output logic [7:0]        memoryReadData,
  output logic              memoryWriteComplete,
  output logic              memoryReadComplete,
  output logic              outOfRange,
  output logic              busRequest,
  input  logic              busGrant,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [7:0]        ramDataOut,
  input  logic [7:0]        ramDataIn,
  output logic              ramDataDrive,
  output logic              ramWriteEnable,
  output logic              ramOutputEnable
);
  pixelState_t       state, stateNext;
  logic              isWrite, oorPending, strobeSecond;
  logic              anyReq, captureReq, inRange;
  logic [ADDR_W-1:0] pixelAddress;

  pixel_address_calc #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_addrCalc (
    .xCoord      (memoryXCoord),
    .yCoord      (memoryYCoord),
    .pixelAddress(pixelAddress),
    .inRange     (inRange)
  );

  assign anyReq     = memoryWriteRequest | memoryReadRequest;
  assign captureReq = (state == IDLE) && !oorPending && anyReq;

  // An out-of-range request spends one cycle in IDLE with oorPending set,
  // so its complete pulse lands one edge after capture without touching the bus.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (oorPending)            stateNext = DONE;
                else if (anyReq && inRange) stateNext = ARB;
      ARB:      if (busGrant)              stateNext = isWrite ? W_SETUP : R_SETUP;
      W_SETUP:  stateNext = W_STROBE;
      W_STROBE: if (strobeSecond)          stateNext = W_HOLD;
      W_HOLD:   stateNext = DONE;
      R_SETUP:  stateNext = R_SAMPLE;
      R_SAMPLE: stateNext = DONE;
      DONE:     stateNext = RELEASE;
      RELEASE:  if (!(isWrite ? memoryWriteRequest : memoryReadRequest)) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Outputs are decoded from stateNext so they change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      isWrite             <= 1'b0;
      oorPending          <= 1'b0;
      strobeSecond        <= 1'b0;
      ramAddress          <= '0;
      ramDataOut          <= '0;
      memoryReadData      <= '0;
      memoryWriteComplete <= 1'b0;
      memoryReadComplete  <= 1'b0;
      outOfRange          <= 1'b0;
      busRequest          <= 1'b0;
      ramDataDrive        <= 1'b0;
      ramWriteEnable      <= 1'b1;
      ramOutputEnable     <= 1'b1;
    end else begin
      state        <= stateNext;
      strobeSecond <= (state == W_STROBE) && !strobeSecond;
      oorPending   <= captureReq && !inRange;
      if (captureReq) begin
        isWrite    <= memoryWriteRequest;
        ramDataOut <= memoryWriteData;
        if (inRange) ramAddress <= pixelAddress;
      end
      busRequest          <= stateNext inside {ARB, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_SAMPLE};
      ramDataDrive        <= stateNext inside {W_SETUP, W_STROBE, W_HOLD};
      ramWriteEnable      <= !(stateNext == W_STROBE);
      ramOutputEnable     <= !(stateNext inside {R_SETUP, R_SAMPLE});
      memoryWriteComplete <= (stateNext == DONE) && isWrite;
      memoryReadComplete  <= (stateNext == DONE) && !isWrite;
      outOfRange          <= (state == IDLE) && (stateNext == DONE);
      if ((stateNext == DONE) && !isWrite)
        memoryReadData <= (state == R_SAMPLE) ? ramDataIn : 8'h00;
    end
  end
endmodule

// File: tb/tb_mpu_pixel_responder.sv
// Randomized + directed bench: transaction-level reference (address, latency,
// strobe counts, memory contents) checked against an observed SRAM bus.
module tb_mpu_pixel_responder;
  localparam int W = 320, H = 240, NPIX = W * H;

  logic        clock = 1'b0, reset = 1'b1;
  logic [8:0]  memoryXCoord = '0;
  logic [7:0]  memoryYCoord = '0, memoryWriteData = '0, memoryReadData;
  logic        memoryWriteRequest = 1'b0, memoryReadRequest = 1'b0;
  logic        memoryWriteComplete, memoryReadComplete, outOfRange, busRequest;
  logic        busGrant = 1'b0;
  logic [16:0] ramAddress;
  logic [7:0]  ramDataOut, ramDataIn = '0;
  logic        ramDataDrive, ramWriteEnable, ramOutputEnable;

  always #5 clock = ~clock;

  mpu_pixel_responder dut (
    .clock(clock), .reset(reset),
    .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
    .memoryWriteRequest(memoryWriteRequest), .memoryReadRequest(memoryReadRequest),
    .memoryWriteData(memoryWriteData), .memoryReadData(memoryReadData),
    .memoryWriteComplete(memoryWriteComplete), .memoryReadComplete(memoryReadComplete),
    .outOfRange(outOfRange), .busRequest(busRequest), .busGrant(busGrant),
    .ramAddress(ramAddress), .ramDataOut(ramDataOut), .ramDataIn(ramDataIn),
    .ramDataDrive(ramDataDrive), .ramWriteEnable(ramWriteEnable),
    .ramOutputEnable(ramOutputEnable)
  );

  int errCnt = 0, chkCnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    chkCnt++;
    if (got != exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] sram   [NPIX];
  logic [7:0] refMem [NPIX];
  int t, firstDone, wrPulses, rdPulses, weLow, oeLow, busHigh, oorPulses;
  int addrBad, protoBad, grantAt, expAddr, expRdHold;

  task automatic clearObs();
    t = -1; firstDone = -1; wrPulses = 0; rdPulses = 0; weLow = 0; oeLow = 0;
    busHigh = 0; oorPulses = 0; addrBad = 0; protoBad = 0;
  endtask

  // One clock: sample after the edge, play the SRAM and the bus arbiter.
  task automatic step();
    @(posedge clock); #1;
    t++;
    if (t == grantAt) busGrant = 1'b1;
    if (memoryWriteComplete) wrPulses++;
    if (memoryReadComplete)  rdPulses++;
    if (firstDone < 0 && (memoryWriteComplete || memoryReadComplete)) firstDone = t;
    if (busRequest) busHigh++;
    if (outOfRange) oorPulses++;
    if (!ramWriteEnable) begin
      weLow++;
      if (int'(ramAddress) != expAddr) addrBad++;
      if (int'(ramAddress) < NPIX) sram[ramAddress] = ramDataOut;
    end
    if (!ramOutputEnable) begin
      oeLow++;
      if (int'(ramAddress) != expAddr) addrBad++;
      ramDataIn = (int'(ramAddress) < NPIX) ? sram[ramAddress] : 8'h00;
    end
    if ((!ramWriteEnable && !ramOutputEnable) || (ramDataDrive && !ramOutputEnable) ||
        (!ramWriteEnable && !ramDataDrive)) protoBad++;
  endtask

  // One request end to end. pre = idle edges before the FSM can capture it.
  task automatic doReq(input string nm, input bit wr, input bit rd, input int x, input int y,
                       input logic [7:0] data, input int d, input int hold, input int pre);
    bit inR;
    int lat, e;
    inR = (x < W) && (y < H);
    expAddr = y * W + x;
    lat = pre + (!inR ? 1 : (wr ? 5 : 3) + d);
    if (wr && inR) refMem[expAddr] = data;
    clearObs();
    grantAt = d;
    busGrant = (d == 0);
    memoryXCoord = 9'(x);
    memoryYCoord = 8'(y);
    memoryWriteData = data;
    memoryWriteRequest = wr;
    memoryReadRequest = rd;
    while (firstDone < 0 && t < lat + 40) step();
    chk($sformatf("%s.latency", nm), firstDone, lat);
    if (rd && !wr) begin
      e = inR ? int'(refMem[expAddr]) : 0;
      chk($sformatf("%s.rdata", nm), int'(memoryReadData), e);
      expRdHold = e;
    end
    repeat (hold) step();
    if (wr && rd) memoryWriteRequest = 1'b0;
    else begin
      memoryWriteRequest = 1'b0;
      memoryReadRequest = 1'b0;
      repeat (2) step();
    end
    chk($sformatf("%s.wrPulses", nm), wrPulses, int'(wr));
    chk($sformatf("%s.rdPulses", nm), rdPulses, int'(rd && !wr));
    chk($sformatf("%s.oorPulses", nm), oorPulses, int'(!inR));
    chk($sformatf("%s.weLowCycles", nm), weLow, (wr && inR) ? 2 : 0);
    chk($sformatf("%s.oeLowCycles", nm), oeLow, (!wr && rd && inR) ? 2 : 0);
    chk($sformatf("%s.busReqCycles", nm), busHigh, inR ? lat - pre : 0);
    chk($sformatf("%s.addrErrors", nm), addrBad, 0);
    chk($sformatf("%s.protoErrors", nm), protoBad, 0);
    if (wr) chk($sformatf("%s.rdHold", nm), int'(memoryReadData), expRdHold);
  endtask

  initial begin
    int px[$], py[$];
    int x, y, k;
    bit wr;
    for (int i = 0; i < NPIX; i++) begin
      sram[i]   = 8'(i) ^ 8'h5A;
      refMem[i] = 8'(i) ^ 8'h5A;
    end
    clearObs();
    grantAt = -5; expAddr = -1; expRdHold = 0;

    repeat (2) step();
    chk("reset.we_n",  int'(ramWriteEnable), 1);
    chk("reset.oe_n",  int'(ramOutputEnable), 1);
    chk("reset.busReq", int'(busRequest), 0);
    chk("reset.drive", int'(ramDataDrive), 0);
    chk("reset.pulses", int'({memoryWriteComplete, memoryReadComplete, outOfRange}), 0);
    chk("reset.addr",  int'(ramAddress), 0);
    chk("reset.rdata", int'(memoryReadData), 0);
    reset = 1'b0;
    step();

    doReq("wr5_2", 1, 0, 5, 2, 8'hA5, 0, 0, 0);
    chk("wr5_2.sram", int'(sram[645]), 'hA5);

    sram[NPIX-1] = 8'h3C; refMem[NPIX-1] = 8'h3C;
    doReq("rd319_239", 0, 1, 319, 239, 8'h00, 0, 0, 0);

    doReq("wrOor320", 1, 0, 320, 0, 8'h77, 0, 0, 0);
    doReq("rdOorY240", 0, 1, 0, 240, 8'h00, 0, 0, 0);

    // write wins over a same-cycle read; read served once the write request drops
    doReq("both.wr", 1, 1, 10, 10, 8'hC3, 10, 0, 0);
    doReq("both.rd", 0, 1, 10, 10, 8'h00, 0, 0, 2);

    doReq("holdHigh", 1, 0, 100, 100, 8'h11, 0, 20, 0);
    doReq("holdHighRd", 0, 1, 100, 100, 8'h00, 1, 20, 0);

    // reset while WE# is low aborts without a complete pulse
    clearObs();
    grantAt = -5; busGrant = 1'b1; expAddr = 60 * W + 50;
    memoryXCoord = 9'd50; memoryYCoord = 8'd60; memoryWriteData = 8'h99;
    memoryWriteRequest = 1'b1;
    while (ramWriteEnable && t < 20) step();
    chk("rstMid.strobeSeen", int'(ramWriteEnable), 0);
    reset = 1'b1;
    step();
    chk("rstMid.we_n", int'(ramWriteEnable), 1);
    chk("rstMid.busReq", int'(busRequest), 0);
    chk("rstMid.drive", int'(ramDataDrive), 0);
    memoryWriteRequest = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    chk("rstMid.noComplete", wrPulses, 0);
    expRdHold = 0;
    doReq("rstMid.reissue", 1, 0, 50, 60, 8'h99, 0, 0, 0);
    doReq("rstMid.readback", 0, 1, 50, 60, 8'h00, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      if (!wr && px.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, px.size() - 1);
        x = px[k]; y = py[k];
      end else begin
        x = $urandom_range(0, 335);
        y = $urandom_range(0, 250);
      end
      doReq($sformatf("rnd%0d", n), wr, !wr, x, y, 8'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), 0);
      if (wr && x < W && y < H) begin
        px.push_back(x); py.push_back(y);
      end
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
